// File: rtl/ber_pkg.sv
// Shared definitions for the BER checker: FSM state encoding, PRBS9 reference
// geometry and a counter-width helper.
package ber_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEED   = 2'd1,
        ST_VERIFY = 2'd2,
        ST_LOCKED = 2'd3
    } ber_state_t;

    // PRBS9, x^9 + x^5 + 1: prediction is r[8] ^ r[4], r[0] newest
    localparam int PRBS_LEN   = 9;
    localparam int PRBS_TAP_A = 8;
    localparam int PRBS_TAP_B = 4;

    // Bits shifted in from the line before the reference is trusted
    localparam int SEED_LEN = PRBS_LEN;

    // Bits needed for a counter that runs 0..n-1
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/prbs9_ref_gen.sv
// Local PRBS9 reference register: loads line bits while seeding, free-runs on
// its own prediction otherwise. i_clear has priority over a shift.
module prbs9_ref_gen
    import ber_pkg::*;
(
    input  logic clock,
    input  logic i_reset,
    input  logic i_load_bit,
    input  logic i_shift,
    input  logic i_load_mode,
    input  logic i_clear,
    output logic o_pred
);

    logic [PRBS_LEN-1:0] r_ref;
    logic                w_in_bit;

    assign o_pred   = r_ref[PRBS_TAP_A] ^ r_ref[PRBS_TAP_B];
    assign w_in_bit = i_load_mode ? i_load_bit : o_pred;

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            r_ref <= '0;
        end else if (i_clear) begin
            r_ref <= '0;
        end else if (i_shift) begin
            r_ref <= {r_ref[PRBS_LEN-2:0], w_in_bit};
        end
    end

endmodule

// File: rtl/ber_checker.sv
// PRBS9 bit-error-rate checker: decimates the FIR output, slices to bits,
// self-synchronises a PRBS9 reference and counts bits/errors while locked.
// Optional macro BER_CLEAR_EN adds the i_clear counter-clear port.
module ber_checker
    import ber_pkg::*;
#(
    parameter int NB_DATA    = 8,
    parameter int N_OS       = 4,
    parameter int NB_PHASE   = 2,
    parameter int VERIFY_LEN = 32,
    parameter int WIN_LEN    = 64,
    parameter int LOSS_THR   = 8,
    parameter int NB_CNT     = 32
) (
    input  logic                       clock,
    input  logic                       i_reset,
    input  logic                       i_enable,
`ifdef BER_CLEAR_EN
    input  logic                       i_clear,
`endif
    input  logic                       i_valid,
    input  logic signed [NB_DATA-1:0]  i_data,
    input  logic        [NB_PHASE-1:0] i_phase,
    output logic                       o_bit,
    output logic                       o_bit_valid,
    output logic                       o_lock,
    output logic        [NB_CNT-1:0]   o_bit_count,
    output logic        [NB_CNT-1:0]   o_err_count
);

    localparam int NB_SEED = cnt_width(SEED_LEN);
    localparam int NB_VER  = cnt_width(VERIFY_LEN);
    localparam int NB_WBIT = cnt_width(WIN_LEN);
    localparam int NB_WERR = cnt_width(LOSS_THR + 1);

    localparam logic [NB_PHASE:0]   N_OS_EXT   = (NB_PHASE+1)'(N_OS);
    localparam logic [NB_PHASE-1:0] PHASE_LAST = NB_PHASE'(N_OS - 1);
    localparam logic [NB_CNT-1:0]   CNT_MAX    = {NB_CNT{1'b1}};

    // ------------------------------------------------------------------
    // Decimator and slicer
    // ------------------------------------------------------------------
    logic [NB_PHASE-1:0] r_phase_cnt;
    logic                r_bit;
    logic                r_bit_valid;
    logic                w_phase_ok;
    logic                w_sel;

    assign w_phase_ok = ({1'b0, i_phase} < N_OS_EXT);
    assign w_sel      = i_valid && w_phase_ok && (r_phase_cnt == i_phase);

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            r_phase_cnt <= '0;
            r_bit       <= 1'b0;
            r_bit_valid <= 1'b0;
        end else begin
            r_bit_valid <= w_sel;
            if (w_sel) begin
                r_bit <= i_data[NB_DATA-1];
            end
            if (!i_enable) begin
                r_phase_cnt <= '0;
            end else if (i_valid) begin
                r_phase_cnt <= (r_phase_cnt == PHASE_LAST) ? '0 : r_phase_cnt + NB_PHASE'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Reference generator
    // ------------------------------------------------------------------
    ber_state_t          r_state;
    logic [NB_SEED-1:0]  r_seed_cnt;
    logic [NB_VER-1:0]   r_verify_cnt;
    logic [NB_WBIT-1:0]  r_win_bit;
    logic [NB_WERR-1:0]  r_win_err;
    logic                r_lock;
    logic [NB_CNT-1:0]   r_bit_count;
    logic [NB_CNT-1:0]   r_err_count;

    logic                w_pred;
    logic                w_mismatch;
    logic                w_active;
    logic                w_shift;
    logic                w_load_mode;
    logic                w_ref_clear;
    logic [NB_WERR-1:0]  w_win_err_next;
    logic                w_loss;

    assign w_mismatch     = r_bit ^ w_pred;
    assign w_active       = i_enable && r_bit_valid;
    assign w_shift        = w_active && (r_state != ST_IDLE);
    assign w_load_mode    = (r_state == ST_SEED);
    assign w_win_err_next = r_win_err + NB_WERR'(w_mismatch);
    assign w_loss         = (w_win_err_next == NB_WERR'(LOSS_THR));
    assign w_ref_clear    = w_active && (r_state == ST_LOCKED) && w_loss;

    prbs9_ref_gen u_ref (
        .clock       (clock),
        .i_reset     (i_reset),
        .i_load_bit  (r_bit),
        .i_shift     (w_shift),
        .i_load_mode (w_load_mode),
        .i_clear     (w_ref_clear),
        .o_pred      (w_pred)
    );

    // ------------------------------------------------------------------
    // Acquisition / tracking FSM and counters
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state      <= ST_IDLE;
            r_seed_cnt   <= '0;
            r_verify_cnt <= '0;
            r_win_bit    <= '0;
            r_win_err    <= '0;
            r_lock       <= 1'b0;
            r_bit_count  <= '0;
            r_err_count  <= '0;
        end else begin
            if (!i_enable) begin
                r_state    <= ST_IDLE;
                r_lock     <= 1'b0;
                r_seed_cnt <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state    <= ST_SEED;
                        r_seed_cnt <= '0;
                    end
                    ST_SEED: begin
                        if (r_bit_valid) begin
                            if (r_seed_cnt == NB_SEED'(SEED_LEN - 1)) begin
                                r_state      <= ST_VERIFY;
                                r_verify_cnt <= '0;
                            end else begin
                                r_seed_cnt <= r_seed_cnt + NB_SEED'(1);
                            end
                        end
                    end
                    ST_VERIFY: begin
                        if (r_bit_valid) begin
                            if (w_mismatch) begin
                                r_state    <= ST_SEED;
                                r_seed_cnt <= '0;
                            end else if (r_verify_cnt == NB_VER'(VERIFY_LEN - 1)) begin
                                r_state     <= ST_LOCKED;
                                r_lock      <= 1'b1;
                                r_bit_count <= '0;
                                r_err_count <= '0;
                                r_win_bit   <= '0;
                                r_win_err   <= '0;
                            end else begin
                                r_verify_cnt <= r_verify_cnt + NB_VER'(1);
                            end
                        end
                    end
                    ST_LOCKED: begin
                        if (r_bit_valid) begin
                            if (r_bit_count != CNT_MAX) begin
                                r_bit_count <= r_bit_count + NB_CNT'(1);
                            end
                            if (w_mismatch && (r_err_count != CNT_MAX)) begin
                                r_err_count <= r_err_count + NB_CNT'(1);
                            end
                            // The loss bit itself is still counted before the counts freeze
                            if (w_loss) begin
                                r_state    <= ST_SEED;
                                r_lock     <= 1'b0;
                                r_seed_cnt <= '0;
                                r_win_bit  <= '0;
                                r_win_err  <= '0;
                            end else if (r_win_bit == NB_WBIT'(WIN_LEN - 1)) begin
                                r_win_bit <= '0;
                                r_win_err <= '0;
                            end else begin
                                r_win_bit <= r_win_bit + NB_WBIT'(1);
                                r_win_err <= w_win_err_next;
                            end
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_lock  <= 1'b0;
                    end
                endcase
            end
`ifdef BER_CLEAR_EN
            if (i_clear) begin
                r_bit_count <= '0;
                r_err_count <= '0;
            end
`endif
        end
    end

    assign o_bit       = r_bit;
    assign o_bit_valid = r_bit_valid;
    assign o_lock      = r_lock;
    assign o_bit_count = r_bit_count;
    assign o_err_count = r_err_count;

endmodule
